serial_word_pusher: RTL and testbench
=====================================

Name: serial_word_pusher

Overview:
- Upstream producer for the team's `fifo` block.
- Deserializes a framed, MSB-first serial bit stream into DATA_W-bit words and drives the FIFO write side (`push`, `data_in`).
- Honours the FIFO's `full` flag through a one-word hold register.
- Drops and counts words that arrive while the hold register is still occupied.

Parameters:
- DATA_W, 10, word width; must equal the downstream FIFO DATA_W.
- CNT_W, 8, width of the overflow counter.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_valid  in  1  bit_in and frame_start are sampled on edges where this is 1.
- bit_in  in  1  serial data bit, MSB first.
- frame_start  in  1  qualified by bit_valid; marks the current bit as bit 0 (MSB) of a new word.
- full  in  1  FIFO full flag, combinational from the FIFO.
- push  out  1  FIFO write strobe.
- data_out  out  DATA_W  word to the FIFO data_in.
- overflow_cnt  out  CNT_W  number of words dropped, saturating.
- parity_err  out  1  one-cycle pulse on a parity failure; tied 0 when PARITY_EN is undefined.
- busy  out  1  high while in SHIFT/PARITY or while the hold register is occupied.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, bit counter=0, shift reg=0, hold reg=0, pend=0.
  - overflow_cnt=0, parity_err=0, so push=0, data_out=0, busy=0.
  - Reset overrides all other inputs, including mid-word; any partial word and any held word are discarded.
- IDLE:
  - Edge with bit_valid=1 & frame_start=1: shift in bit_in, counter=1, go to SHIFT.
  - bit_valid without frame_start is ignored.
- SHIFT:
  - Each bit_valid edge shifts bit_in into the LSB and increments the counter.
  - Edges with bit_valid=0 hold all state; gaps of any length are legal.
  - When the DATA_W-th bit is shifted in, the word is complete; go to IDLE (or PARITY when PARITY_EN).
- frame_start=1 with bit_valid=1 while in SHIFT (mid-word):
  - Discard the partial word; this bit becomes the MSB of a new word, counter=1.
  - No count, no error.
- Word completion:
  - If pend=0, or push is high in that same cycle, load the hold register with the word and set pend=1.
  - Otherwise drop the word and increment overflow_cnt, saturating at 2^CNT_W-1.
- push = pend & ~full, combinational. data_out = hold register (stable while pend=1).
- An edge with push=1 clears pend, unless a word completes on that same edge, in which case the new word loads and pend stays 1.
- Latency: last data bit sampled at edge N; push can assert in cycle N+1 if full=0. Max throughput is one word per DATA_W bit_valid cycles.
- full held high: push stays 0 indefinitely and data_out is held. No timeout.

Optional Feature:
- Macro: SERIAL_WORD_PUSHER_PARITY_EN.
- Defined:
  - After the DATA_W-th bit the FSM enters PARITY and the next bit_valid bit is an even-parity bit over the data.
  - Good parity: word proceeds to the hold logic at that edge (latency +1 bit).
  - Bad parity: word is discarded, parity_err pulses for exactly one cycle after that edge, overflow_cnt is unchanged.
  - frame_start in PARITY aborts the word as in SHIFT.
- Undefined: no PARITY state; parity_err is constant 0.

Test Plan:
- Reset, then frame 101 (0b0001100101) with continuous bit_valid and full=0 -> push high for exactly one cycle after the 10th bit edge, data_out=101, overflow_cnt=0.
- full=1, frame 202 -> push stays 0, data_out=202 held. Drop full after 5 cycles -> push high for one cycle with 202, busy then falls.
- full=1, frames 11 then 22 back-to-back -> 22 dropped, overflow_cnt=1. Release full -> single push of 11 only.
- Frame 5 bits of 44, then frame_start plus full frame 303 -> only 303 pushed, overflow_cnt unchanged. Also inject bit_valid=0 gaps of 3 cycles mid-word -> result unchanged.
- rst=1 for one cycle after 6 bits of 55 (and separately with pend=1, full=1) -> no push ever for 55, all outputs 0 the next cycle. Next frame 33 is pushed normally.
- With SERIAL_WORD_PUSHER_PARITY_EN: 101 with parity bit 0 -> push with 101. 101 with parity bit 1 -> parity_err pulses once, no push, overflow_cnt=0.

Source files
------------

// File: rtl/serial_word_pusher_if.sv
// Serial-in / FIFO-write-side bundle for serial_word_pusher.
// master = the pusher, slave = the bit source plus the downstream FIFO.
interface serial_word_pusher_if #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned CNT_W  = 8
);
  logic              bit_valid;
  logic              bit_in;
  logic              frame_start;
  logic              full;
  logic              push;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  overflow_cnt;
  logic              parity_err;
  logic              busy;

  modport master (
    input  bit_valid, bit_in, frame_start, full,
    output push, data_out, overflow_cnt, parity_err, busy
  );

  modport slave (
    output bit_valid, bit_in, frame_start, full,
    input  push, data_out, overflow_cnt, parity_err, busy
  );
endinterface

// File: rtl/serial_word_pusher.sv
// Deserializes a framed MSB-first bit stream into words and feeds a FIFO via a one-word hold register.
// Optional trailing even-parity bit per word: define SERIAL_WORD_PUSHER_PARITY_EN.
module serial_word_pusher #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  serial_word_pusher_if.master bus
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SERIAL_WORD_PUSHER_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]           state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic [DATA_W-1:0]    hold_q, hold_d;
  logic                 pend_q, pend_d;
  logic [CNT_W-1:0]     ovf_q, ovf_d;

  logic                 push_c;
  logic                 word_done;
  logic [DATA_W-1:0]    word_val;
  logic [DATA_W-1:0]    shifted;

`ifdef SERIAL_WORD_PUSHER_PARITY_EN
  logic perr_q, perr_d;
`endif

  assign push_c = pend_q & ~bus.full;

  // Next-state: deserializer FSM, then hold-register / overflow bookkeeping
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    word_done = 1'b0;
    word_val  = shift_q;
    shifted   = {shift_q[DATA_W-2:0], bus.bit_in};
`ifdef SERIAL_WORD_PUSHER_PARITY_EN
    perr_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.bit_valid && bus.frame_start) begin
          shift_d = DATA_W'(bus.bit_in);
          cnt_d   = BIT_CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.bit_valid) begin
          if (bus.frame_start) begin
            shift_d = DATA_W'(bus.bit_in);
            cnt_d   = BIT_CNT_W'(1);
          end else if (cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
            shift_d = shifted;
            cnt_d   = '0;
`ifdef SERIAL_WORD_PUSHER_PARITY_EN
            state_d = PARITY;
`else
            state_d   = IDLE;
            word_done = 1'b1;
            word_val  = shifted;
`endif
          end else begin
            shift_d = shifted;
            cnt_d   = cnt_q + BIT_CNT_W'(1);
          end
        end
      end
`ifdef SERIAL_WORD_PUSHER_PARITY_EN
      PARITY: begin
        if (bus.bit_valid) begin
          if (bus.frame_start) begin
            shift_d = DATA_W'(bus.bit_in);
            cnt_d   = BIT_CNT_W'(1);
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
            if ((^shift_q) == bus.bit_in) begin
              word_done = 1'b1;
              word_val  = shift_q;
            end else begin
              perr_d = 1'b1;
            end
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A push on the same edge frees the slot for the incoming word
    if (word_done) begin
      if (!pend_q || push_c) begin
        hold_d = word_val;
        pend_d = 1'b1;
      end else if (ovf_q != {CNT_W{1'b1}}) begin
        ovf_d = ovf_q + CNT_W'(1);
      end
    end else if (push_c) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef SERIAL_WORD_PUSHER_PARITY_EN
  always_ff @(posedge clock) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.push         = push_c;
  assign bus.data_out     = hold_q;
  assign bus.overflow_cnt = ovf_q;
  assign bus.busy         = (state_q != IDLE) | pend_q;

endmodule

// File: tb/tb_serial_word_pusher.sv
// Directed bench for serial_word_pusher: table of single frames plus hand sequences for full/abort/reset/parity.
module tb_serial_word_pusher;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned CNT_W  = 8;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  serial_word_pusher_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  serial_word_pusher #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DATA_W-1:0] word;
    int                gap_after;
    int                gap_len;
    logic [DATA_W-1:0] exp_data;
    logic [CNT_W-1:0]  exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    bus.bit_valid   = 1'b1;
    bus.bit_in      = b;
    bus.frame_start = fs;
    tick();
    bus.bit_valid   = 1'b0;
    bus.bit_in      = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  // Sends data bits MSB first, optional idle gap after bit index gap_after, then parity if built in
  task automatic send_word(input logic [DATA_W-1:0] w, input int gap_after, input int gap_len);
    for (int i = 0; i < int'(DATA_W); i++) begin
      send_bit(w[DATA_W-1-i], i == 0);
      if (i == gap_after)
        for (int g = 0; g < gap_len; g++) tick();
    end
`ifdef SERIAL_WORD_PUSHER_PARITY_EN
    send_bit(^w, 1'b0);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".push"},   32'(bus.push), 32'd0);
    chk({tag, ".data"},   32'(bus.data_out), 32'd0);
    chk({tag, ".ovf"},    32'(bus.overflow_cnt), 32'd0);
    chk({tag, ".perr"},   32'(bus.parity_err), 32'd0);
    chk({tag, ".busy"},   32'(bus.busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{10'd101, -1, 0, 10'd101, 8'd0};
    vecs[1] = '{10'd0,   -1, 0, 10'd0,   8'd0};
    vecs[2] = '{10'd1023, 4, 3, 10'd1023, 8'd0};
    vecs[3] = '{10'h2AA,  0, 1, 10'h2AA, 8'd0};
    vecs[4] = '{10'h155,  8, 5, 10'h155, 8'd0};
    vecs[5] = '{10'd512, -1, 0, 10'd512, 8'd0};

    bus.bit_valid   = 1'b0;
    bus.bit_in      = 1'b0;
    bus.frame_start = 1'b0;
    bus.full        = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_all_zero("reset");

    // Table: single frames with full=0, push exactly one cycle after the last bit
    foreach (vecs[k]) begin
      send_word(vecs[k].word, vecs[k].gap_after, vecs[k].gap_len);
      chk($sformatf("vec%0d.push", k), 32'(bus.push), 32'd1);
      chk($sformatf("vec%0d.data", k), 32'(bus.data_out), 32'(vecs[k].exp_data));
      chk($sformatf("vec%0d.ovf", k),  32'(bus.overflow_cnt), 32'(vecs[k].exp_ovf));
      tick();
      chk($sformatf("vec%0d.push_off", k), 32'(bus.push), 32'd0);
      chk($sformatf("vec%0d.busy_off", k), 32'(bus.busy), 32'd0);
    end

    // full held: word waits in the hold register
    bus.full = 1'b1;
    send_word(10'd202, -1, 0);
    for (int c = 0; c < 5; c++) begin
      chk("full202.push", 32'(bus.push), 32'd0);
      chk("full202.data", 32'(bus.data_out), 32'd202);
      chk("full202.busy", 32'(bus.busy), 32'd1);
      tick();
    end
    bus.full = 1'b0;
    #1;
    chk("rel202.push", 32'(bus.push), 32'd1);
    chk("rel202.data", 32'(bus.data_out), 32'd202);
    tick();
    chk("rel202.push_off", 32'(bus.push), 32'd0);
    chk("rel202.busy_off", 32'(bus.busy), 32'd0);

    // Two frames while full: second is dropped and counted
    bus.full = 1'b1;
    send_word(10'd11, -1, 0);
    send_word(10'd22, -1, 0);
    chk("drop.ovf",  32'(bus.overflow_cnt), 32'd1);
    chk("drop.data", 32'(bus.data_out), 32'd11);
    chk("drop.push", 32'(bus.push), 32'd0);
    tick();
    bus.full = 1'b0;
    #1;
    chk("drop.rel_push", 32'(bus.push), 32'd1);
    chk("drop.rel_data", 32'(bus.data_out), 32'd11);
    tick();
    chk("drop.second_push", 32'(bus.push), 32'd0);
    chk("drop.busy_off",    32'(bus.busy), 32'd0);
    for (int c = 0; c < 3; c++) tick();
    chk("drop.no_late_push", 32'(bus.push), 32'd0);

    // Abort: 5 bits of 44, then a fresh frame 303 with a 3-cycle gap mid-word
    begin
      logic [DATA_W-1:0] w44;
      w44 = 10'd44;
      for (int i = 0; i < 5; i++) send_bit(w44[DATA_W-1-i], i == 0);
    end
    send_word(10'd303, 5, 3);
    chk("abort.push", 32'(bus.push), 32'd1);
    chk("abort.data", 32'(bus.data_out), 32'd303);
    chk("abort.ovf",  32'(bus.overflow_cnt), 32'd1);
    tick();
    chk("abort.push_off", 32'(bus.push), 32'd0);

    // Reset mid-word: partial 55 discarded, trailing bits ignored in IDLE
    begin
      logic [DATA_W-1:0] w55;
      w55 = 10'd55;
      for (int i = 0; i < 6; i++) send_bit(w55[DATA_W-1-i], i == 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_all_zero("rst_mid");
      for (int i = 6; i < int'(DATA_W); i++) begin
        send_bit(w55[DATA_W-1-i], 1'b0);
        chk("rst_mid.no_push", 32'(bus.push), 32'd0);
      end
      tick();
      chk("rst_mid.no_push_end", 32'(bus.push), 32'd0);
    end

    // Reset with a held word behind full
    bus.full = 1'b1;
    send_word(10'd55, -1, 0);
    chk("rst_pend.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.full = 1'b0;
    #1;
    chk_all_zero("rst_pend");
    tick();
    chk("rst_pend.no_push", 32'(bus.push), 32'd0);

    send_word(10'd33, -1, 0);
    chk("post_rst.push", 32'(bus.push), 32'd1);
    chk("post_rst.data", 32'(bus.data_out), 32'd33);
    chk("post_rst.ovf",  32'(bus.overflow_cnt), 32'd0);
    tick();
    chk("post_rst.push_off", 32'(bus.push), 32'd0);
    chk("post_rst.perr", 32'(bus.parity_err), 32'd0);

`ifdef SERIAL_WORD_PUSHER_PARITY_EN
    // Bad parity on 101 (four ones, so 1 is wrong)
    begin
      logic [DATA_W-1:0] w101;
      w101 = 10'd101;
      for (int i = 0; i < int'(DATA_W); i++) send_bit(w101[DATA_W-1-i], i == 0);
      chk("par_bad.pre_push", 32'(bus.push), 32'd0);
      send_bit(1'b1, 1'b0);
      chk("par_bad.perr", 32'(bus.parity_err), 32'd1);
      chk("par_bad.push", 32'(bus.push), 32'd0);
      tick();
      chk("par_bad.perr_off", 32'(bus.parity_err), 32'd0);
      chk("par_bad.push_off", 32'(bus.push), 32'd0);
      chk("par_bad.ovf",      32'(bus.overflow_cnt), 32'd0);
      chk("par_bad.busy",     32'(bus.busy), 32'd0);
      for (int i = 0; i < int'(DATA_W); i++) send_bit(w101[DATA_W-1-i], i == 0);
      send_bit(1'b0, 1'b0);
      chk("par_good.push", 32'(bus.push), 32'd1);
      chk("par_good.data", 32'(bus.data_out), 32'd101);
      chk("par_good.perr", 32'(bus.parity_err), 32'd0);
      tick();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
